// File: rtl/accelerator_pkg.sv
// Shared accelerator types: write-back source tags and write-port arbiter states.
package accelerator_pkg;

    typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ARITH, WB_SRC_LSU} wb_src_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ARITH, ARB_LSU} wb_arb_state_t;

    localparam int unsigned VREG_MAX_BEATS = 8;

endpackage

// File: rtl/vreg_write_arbiter.sv
// Arbitrates the single vector register file write port between ARITH and LSU, holding
// multi-beat register-group writes as atomic bursts and checking burst address order.
module vreg_write_arbiter
    import accelerator_pkg::*;
#(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ELEM_W    = 2,
    parameter int unsigned MAX_BEATS = VREG_MAX_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,

    input  logic              arith_valid_i,
    output logic              arith_ready_o,
    input  logic              arith_last_i,
    input  logic [ADDR_W-1:0] arith_addr_i,
    input  logic [ELEM_W-1:0] arith_elems_i,
    input  logic [DATA_W-1:0] arith_data_i,

    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic              lsu_last_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [ELEM_W-1:0] lsu_elems_i,
    input  logic [DATA_W-1:0] lsu_data_i,

    output logic              vreg_we_o,
    output logic [ADDR_W-1:0] vreg_addr_o,
    output logic [ELEM_W-1:0] vreg_elems_o,
    output logic [DATA_W-1:0] vreg_data_o,
    output wb_src_t           vreg_src_o,

    output logic              busy_o,
    output logic              seq_err_o,
    input  logic              err_clr_i
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    wb_arb_state_t     state_q;
    wb_src_t           rr_last_q;
    logic [ADDR_W-1:0] base_addr_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              seq_err_q;

    logic              gnt_arith;
    logic              gnt_lsu;
    logic              accept;
    logic              tie;
    wb_src_t           sel_src;
    logic              sel_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [ELEM_W-1:0] sel_elems;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] exp_addr;
    logic              seq_bad;

    assign tie = arith_valid_i & lsu_valid_i;

    // Grants depend only on valids and arbiter state, never on beat contents.
    always_comb begin
        gnt_arith = 1'b0;
        gnt_lsu   = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                ARB_IDLE: begin
                    gnt_arith = arith_valid_i & (~lsu_valid_i | (rr_last_q != WB_SRC_ARITH));
                    gnt_lsu   = lsu_valid_i & (~arith_valid_i | (rr_last_q == WB_SRC_ARITH));
                end
                ARB_ARITH: gnt_arith = arith_valid_i;
                ARB_LSU:   gnt_lsu   = lsu_valid_i;
                default: ;
            endcase
        end
    end

    assign arith_ready_o = gnt_arith;
    assign lsu_ready_o   = gnt_lsu;
    assign accept        = gnt_arith | gnt_lsu;

    assign sel_src   = gnt_arith ? WB_SRC_ARITH : WB_SRC_LSU;
    assign sel_last  = gnt_arith ? arith_last_i  : lsu_last_i;
    assign sel_addr  = gnt_arith ? arith_addr_i  : lsu_addr_i;
    assign sel_elems = gnt_arith ? arith_elems_i : lsu_elems_i;
    assign sel_data  = gnt_arith ? arith_data_i  : lsu_data_i;

    // Register groups wrap modulo the register file size.
    assign exp_addr = base_addr_q + ADDR_W'(beat_cnt_q);
    assign seq_bad  = accept && (state_q != ARB_IDLE) &&
                      ((sel_addr != exp_addr) ||
                       ((beat_cnt_q == CNT_W'(MAX_BEATS)) && !sel_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            rr_last_q   <= WB_SRC_LSU;
            base_addr_q <= '0;
            beat_cnt_q  <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            if (seq_bad) begin
                seq_err_q <= 1'b1;
            end else if (err_clr_i) begin
                seq_err_q <= 1'b0;
            end

            if (flush_i) begin
                state_q    <= ARB_IDLE;
                beat_cnt_q <= '0;
            end else if (accept) begin
                if (state_q == ARB_IDLE) begin
                    if (tie) begin
                        rr_last_q <= sel_src;
                    end
                    if (!sel_last) begin
                        state_q     <= gnt_arith ? ARB_ARITH : ARB_LSU;
                        base_addr_q <= sel_addr;
                        beat_cnt_q  <= CNT_W'(1);
                    end
                end else if (sel_last) begin
                    state_q    <= ARB_IDLE;
                    beat_cnt_q <= '0;
                end else if (beat_cnt_q < CNT_W'(MAX_BEATS)) begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vreg_we_o    <= 1'b0;
            vreg_src_o   <= WB_SRC_NONE;
            vreg_addr_o  <= '0;
            vreg_elems_o <= '0;
            vreg_data_o  <= '0;
        end else begin
            vreg_we_o  <= accept;
            vreg_src_o <= accept ? sel_src : WB_SRC_NONE;
            if (accept) begin
                vreg_addr_o  <= sel_addr;
                vreg_elems_o <= sel_elems;
                vreg_data_o  <= sel_data;
            end
        end
    end

    assign busy_o    = (state_q != ARB_IDLE);
    assign seq_err_o = seq_err_q;

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Self-checking bench for vreg_write_arbiter: directed scenarios plus randomized bursts,
// all cycles compared against a transaction-level reference model.
module tb_vreg_write_arbiter;
    import accelerator_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush_i;
    logic         err_clr_i;
    logic         av, al, lv, ll;
    logic [4:0]   aa, la;
    logic [1:0]   ae, le;
    logic [127:0] ad, ld;

    logic         arith_ready_o, lsu_ready_o;
    logic         vreg_we_o, busy_o, seq_err_o;
    logic [4:0]   vreg_addr_o;
    logic [1:0]   vreg_elems_o;
    logic [127:0] vreg_data_o;
    wb_src_t      vreg_src_o;

    vreg_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .arith_valid_i (av),
        .arith_ready_o (arith_ready_o),
        .arith_last_i  (al),
        .arith_addr_i  (aa),
        .arith_elems_i (ae),
        .arith_data_i  (ad),
        .lsu_valid_i   (lv),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_last_i    (ll),
        .lsu_addr_i    (la),
        .lsu_elems_i   (le),
        .lsu_data_i    (ld),
        .vreg_we_o     (vreg_we_o),
        .vreg_addr_o   (vreg_addr_o),
        .vreg_elems_o  (vreg_elems_o),
        .vreg_data_o   (vreg_data_o),
        .vreg_src_o    (vreg_src_o),
        .busy_o        (busy_o),
        .seq_err_o     (seq_err_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner of the open burst (0 none, 1 arith, 2 lsu), last tie winner,
    // burst base and beat count, sticky error, and the write expected on the port.
    int           m_owner, m_rr, m_base, m_cnt;
    bit           m_err;
    bit           e_we;
    int           e_src;
    logic [4:0]   e_addr;
    logic [1:0]   e_elems;
    logic [127:0] e_data;
    bit           last_ga, last_gl;

    function automatic void model_reset();
        m_owner = 0; m_rr = 2; m_base = 0; m_cnt = 0; m_err = 0;
        e_we = 0; e_src = 0; e_addr = '0; e_elems = '0; e_data = '0;
        last_ga = 0; last_gl = 0;
    endfunction

    function automatic void idle_inputs();
        av = 0; al = 0; aa = '0; ae = '0; ad = '0;
        lv = 0; ll = 0; la = '0; le = '0; ld = '0;
        flush_i = 0; err_clr_i = 0;
    endfunction

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        bit ga, gl, lst, new_err;
        int src;
        logic [4:0] addr;
        @(negedge clk);
        check("we", 128'(vreg_we_o), 128'(e_we));
        check("src", 128'(vreg_src_o), 128'(e_src));
        if (e_we) begin
            check("addr", 128'(vreg_addr_o), 128'(e_addr));
            check("elems", 128'(vreg_elems_o), 128'(e_elems));
            check("data", vreg_data_o, e_data);
        end
        check("busy", 128'(busy_o), 128'(m_owner != 0));
        check("seq_err", 128'(seq_err_o), 128'(m_err));

        ga = 0; gl = 0;
        if (!flush_i) begin
            if (m_owner == 0) begin
                if (av && lv) begin
                    ga = (m_rr == 2);
                    gl = (m_rr == 1);
                end else begin
                    ga = av;
                    gl = lv;
                end
            end else if (m_owner == 1) begin
                ga = av;
            end else begin
                gl = lv;
            end
        end
        check("arith_ready", 128'(arith_ready_o), 128'(ga));
        check("lsu_ready", 128'(lsu_ready_o), 128'(gl));

        new_err = 0;
        if (ga || gl) begin
            src  = ga ? 1 : 2;
            addr = ga ? aa : la;
            lst  = ga ? al : ll;
            if (m_owner == 0) begin
                if (av && lv) m_rr = src;
                if (!lst) begin
                    m_owner = src; m_base = addr; m_cnt = 1;
                end
            end else begin
                if (int'(addr) != (m_base + m_cnt) % 32 || (m_cnt == 8 && !lst)) new_err = 1;
                if (lst) begin
                    m_owner = 0; m_cnt = 0;
                end else if (m_cnt < 8) begin
                    m_cnt++;
                end
            end
            e_we = 1; e_src = src; e_addr = addr;
            e_elems = ga ? ae : le;
            e_data  = ga ? ad : ld;
        end else begin
            e_we = 0; e_src = 0;
        end
        if (flush_i) begin
            m_owner = 0; m_cnt = 0;
        end
        m_err = new_err || (m_err && !err_clr_i);
        last_ga = ga; last_gl = gl;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [4:0] addr;
        logic       last;
    } beat_t;

    beat_t aq[$];
    beat_t lq[$];

    task automatic gen(input int who);
        int    len, bad;
        beat_t b;
        logic [4:0] base;
        len  = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(1, 4));
        base = 5'($urandom);
        bad  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len)) : -1;
        for (int k = 0; k < len; k++) begin
            b.addr = base + 5'(k);
            if (k == bad) b.addr = b.addr + 5'd1;
            b.last = (k == len - 1);
            if (who == 0) aq.push_back(b);
            else lq.push_back(b);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #12;
        check("rst_we", 128'(vreg_we_o), 128'(0));
        check("rst_src", 128'(vreg_src_o), 128'(WB_SRC_NONE));
        check("rst_addr", 128'(vreg_addr_o), 128'(0));
        check("rst_data", vreg_data_o, 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_seq_err", 128'(seq_err_o), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        // Single beat
        av = 1; al = 1; aa = 5'd3; ad = {16{8'hA5}};
        #1;
        check("single_ready", 128'(arith_ready_o), 128'(1));
        cycle();
        check("single_we", 128'(vreg_we_o), 128'(1));
        check("single_addr", 128'(vreg_addr_o), 128'(3));
        check("single_src", 128'(vreg_src_o), 128'(WB_SRC_ARITH));
        idle_inputs();
        cycle();

        // Tie round-robin
        av = 1; al = 1; aa = 5'd1; lv = 1; ll = 1; la = 5'd2;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_src", 128'(vreg_src_o),
                  128'((i % 2 == 0) ? WB_SRC_ARITH : WB_SRC_LSU));
        end

        // Burst lock: one tie first so the LSU wins the tie that opens its burst
        cycle();
        for (int k = 0; k < 4; k++) begin
            la = 5'(8 + k); ll = (k == 3); aa = 5'd20;
            #1;
            check("lock_arith_ready", 128'(arith_ready_o), 128'(0));
            check("lock_lsu_ready", 128'(lsu_ready_o), 128'(1));
            cycle();
        end
        lv = 0;
        #1;
        check("lock_release", 128'(arith_ready_o), 128'(1));
        cycle();
        idle_inputs();
        cycle();

        // Sequence errors
        av = 1; al = 0; aa = 5'd4;
        cycle();
        al = 1; aa = 5'd6;
        cycle();
        check("seq_gap_err", 128'(seq_err_o), 128'(1));
        av = 0; err_clr_i = 1;
        cycle();
        err_clr_i = 0;
        check("seq_clr", 128'(seq_err_o), 128'(0));
        av = 1; al = 0;
        for (int k = 0; k < 9; k++) begin
            aa = 5'(12 + k);
            err_clr_i = (k == 8);
            cycle();
            if (k == 7) check("seq_eight_ok", 128'(seq_err_o), 128'(0));
        end
        err_clr_i = 0;
        check("seq_nine_err", 128'(seq_err_o), 128'(1));
        aa = 5'd21; al = 1;
        cycle();
        av = 0; err_clr_i = 1;
        cycle();
        err_clr_i = 0;

        // Address wrap
        av = 1; al = 0; aa = 5'd30;
        cycle();
        aa = 5'd31;
        cycle();
        aa = 5'd0; al = 1;
        cycle();
        check("wrap_addr", 128'(vreg_addr_o), 128'(0));
        av = 0;
        cycle();
        check("wrap_no_err", 128'(seq_err_o), 128'(0));

        // Flush mid-burst
        av = 1; al = 0; aa = 5'd0;
        cycle();
        aa = 5'd1;
        cycle();
        aa = 5'd2; flush_i = 1;
        #1;
        check("flush_ready", 128'(arith_ready_o), 128'(0));
        cycle();
        flush_i = 0;
        check("flush_busy", 128'(busy_o), 128'(0));
        aa = 5'd9; al = 1;
        #1;
        check("flush_regrant", 128'(arith_ready_o), 128'(1));
        cycle();
        idle_inputs();
        cycle();

        // Reset mid-burst, with an error and a write in flight
        lv = 1; ll = 0; la = 5'd16;
        cycle();
        la = 5'd18;
        cycle();
        check("pre_rst_we", 128'(vreg_we_o), 128'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_we", 128'(vreg_we_o), 128'(0));
        check("mid_rst_src", 128'(vreg_src_o), 128'(WB_SRC_NONE));
        check("mid_rst_addr", 128'(vreg_addr_o), 128'(0));
        check("mid_rst_data", vreg_data_o, 128'(0));
        check("mid_rst_busy", 128'(busy_o), 128'(0));
        check("mid_rst_err", 128'(seq_err_o), 128'(0));
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (aq.size() == 0) gen(0);
            if (lq.size() == 0) gen(1);
            av = ($urandom_range(0, 3) != 0);
            aa = aq[0].addr; al = aq[0].last;
            ae = 2'($urandom); ad = {$urandom(), $urandom(), $urandom(), $urandom()};
            lv = ($urandom_range(0, 3) != 0);
            la = lq[0].addr; ll = lq[0].last;
            le = 2'($urandom); ld = {$urandom(), $urandom(), $urandom(), $urandom()};
            flush_i   = ($urandom_range(0, 31) == 0);
            err_clr_i = ($urandom_range(0, 15) == 0);
            cycle();
            if (last_ga) void'(aq.pop_front());
            if (last_gl) void'(lq.pop_front());
        end
        idle_inputs();
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
